// File: rtl/wide_addsub_sequencer.sv
// rtl/wide_addsub_sequencer.sv - multi-precision add/subtract sequencer driving one shared WIDTH-bit adder
module wide_addsub_sequencer #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORDS*WIDTH-1:0] in_a,
  input  logic [WORDS*WIDTH-1:0] in_b,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORDS*WIDTH-1:0] out_result,
  output logic                   out_carry,
  output logic                   out_overflow,
  output logic                   out_zero,
  output logic                   busy,
  output logic [WIDTH-1:0]       adder_a,
  output logic [WIDTH-1:0]       adder_b,
  output logic                   adder_cin,
  output logic                   adder_mode,
  input  logic [WIDTH-1:0]       adder_sum,
  input  logic                   adder_cout
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Operands and result are held as word arrays so the active word is a plain index.
  logic [WORDS-1:0][WIDTH-1:0] a_words;
  logic [WORDS-1:0][WIDTH-1:0] b_words;
  logic [WORDS-1:0][WIDTH-1:0] result_words;
  logic [IDX_W-1:0]            idx;
  logic                        carry_reg;
  logic                        sub_reg;
  logic                        a_msb;
  logic                        b_msb;

  assign a_msb = a_words[WORDS-1][WIDTH-1];
  assign b_msb = b_words[WORDS-1][WIDTH-1];

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign out_result = result_words;
  assign out_zero   = (result_words == '0);

  // Adder is only fed during RUN; quiet zeros otherwise so it never toggles idle.
  always_comb begin
    adder_a    = '0;
    adder_b    = '0;
    adder_cin  = 1'b0;
    adder_mode = 1'b0;
    if (state == RUN) begin
      adder_a    = a_words[idx];
      adder_b    = b_words[idx];
      adder_cin  = carry_reg;
      adder_mode = sub_reg;
    end
  end

  // Sequencer FSM: accept operands, walk words LSW first chaining carry, hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      carry_reg    <= 1'b0;
      sub_reg      <= 1'b0;
      a_words      <= '0;
      b_words      <= '0;
      result_words <= '0;
      out_carry    <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_words      <= in_a;
            b_words      <= in_b;
            sub_reg      <= in_sub;
            // Subtract is A + ~B + 1: the +1 enters as the first carry-in.
            carry_reg    <= in_sub;
            idx          <= '0;
            result_words <= '0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          result_words[idx] <= adder_sum;
          carry_reg         <= adder_cout;
          if (idx == LAST_IDX) begin
            idx          <= '0;
            out_carry    <= adder_cout;
            // Signed overflow: effective operand signs agree but result sign differs.
            out_overflow <= (a_msb == (b_msb ^ sub_reg)) &&
                            (adder_sum[WIDTH-1] != a_msb);
            state        <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_addsub_sequencer.sv
// tb/tb_wide_addsub_sequencer.sv - directed vector bench for wide_addsub_sequencer
module tb_wide_addsub_sequencer;

  localparam int WIDTH = 32;
  localparam int WORDS = 4;
  localparam int TW    = WIDTH * WORDS;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_a;
  logic [TW-1:0] in_b;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_result;
  logic          out_carry;
  logic          out_overflow;
  logic          out_zero;
  logic          busy;
  logic [WIDTH-1:0] adder_a;
  logic [WIDTH-1:0] adder_b;
  logic          adder_cin;
  logic          adder_mode;
  logic [WIDTH-1:0] adder_sum;
  logic          adder_cout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external adder: mode inverts b.
  logic [WIDTH:0] adder_full;
  assign adder_full = {1'b0, adder_a} + {1'b0, (adder_mode ? ~adder_b : adder_b)} + {{WIDTH{1'b0}}, adder_cin};
  assign adder_sum  = adder_full[WIDTH-1:0];
  assign adder_cout = adder_full[WIDTH];

  wide_addsub_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry),
    .out_overflow(out_overflow), .out_zero(out_zero),
    .busy(busy),
    .adder_a(adder_a), .adder_b(adder_b),
    .adder_cin(adder_cin), .adder_mode(adder_mode),
    .adder_sum(adder_sum), .adder_cout(adder_cout)
  );

  typedef struct {
    string         name;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          sub;
    logic [TW-1:0] exp_result;
    logic          exp_carry;
    logic          exp_ovf;
    logic          exp_zero;
    logic [3:0]    exp_cins;   // bit k = adder_cin in RUN cycle k+1
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_adder_idle(input string tag);
    chk({tag, "_adder_a"}, TW'(adder_a), '0);
    chk({tag, "_adder_b"}, TW'(adder_b), '0);
    chk({tag, "_adder_cin"}, TW'(adder_cin), '0);
    chk({tag, "_adder_mode"}, TW'(adder_mode), '0);
  endtask

  // Issue one operation, check every RUN cycle and the DONE outputs; leaves DUT in DONE.
  task automatic issue_and_check(input vec_t v);
    logic [TW-1:0] a_tmp;
    logic [TW-1:0] b_tmp;
    chk({v.name, "_in_ready"}, TW'(in_ready), 1);
    in_a = v.a; in_b = v.b; in_sub = v.sub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a_tmp = v.a;
    b_tmp = v.b;
    for (int k = 0; k < WORDS; k++) begin
      chk({v.name, "_busy"}, TW'(busy), 1);
      chk({v.name, "_out_valid_run"}, TW'(out_valid), 0);
      chk({v.name, "_adder_a"}, TW'(adder_a), TW'(a_tmp[k*WIDTH +: WIDTH]));
      chk({v.name, "_adder_b"}, TW'(adder_b), TW'(b_tmp[k*WIDTH +: WIDTH]));
      chk({v.name, "_adder_cin"}, TW'(adder_cin), TW'(v.exp_cins[k]));
      chk({v.name, "_adder_mode"}, TW'(adder_mode), TW'(v.sub));
      tick();
    end
    chk({v.name, "_out_valid"}, TW'(out_valid), 1);
    chk({v.name, "_in_ready_done"}, TW'(in_ready), 0);
    chk({v.name, "_result"}, out_result, v.exp_result);
    chk({v.name, "_carry"}, TW'(out_carry), TW'(v.exp_carry));
    chk({v.name, "_overflow"}, TW'(out_overflow), TW'(v.exp_ovf));
    chk({v.name, "_zero"}, TW'(out_zero), TW'(v.exp_zero));
    check_adder_idle({v.name, "_done"});
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, TW'(in_ready), 1);
    chk({tag, "_out_valid_after"}, TW'(out_valid), 0);
    chk({tag, "_busy_after"}, TW'(busy), 0);
  endtask

  logic [TW-1:0] held_result;
  logic          held_carry;
  logic          held_ovf;
  logic          held_zero;

  initial begin
    vecs[0] = '{"ones_plus_one", {TW{1'b1}}, 128'd1, 1'b0, 128'd0, 1'b1, 1'b0, 1'b1, 4'b1110};
    vecs[1] = '{"zero_minus_one", 128'd0, 128'd1, 1'b1, {TW{1'b1}}, 1'b0, 1'b0, 1'b0, 4'b0001};
    vecs[2] = '{"maxpos_plus_one", {1'b0, {(TW-1){1'b1}}}, 128'd1, 1'b0,
                {1'b1, {(TW-1){1'b0}}}, 1'b0, 1'b1, 1'b0, 4'b1110};
    vecs[3] = '{"half_carry", 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
                128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 4'b0110};
    vecs[4] = '{"five_plus_three", 128'd5, 128'd3, 1'b0, 128'd8, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[5] = '{"equal_sub", 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
                128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 1'b1, 128'd0, 1'b1, 1'b0, 1'b1, 4'b1111};
    vecs[6] = '{"minneg_minus_one", {1'b1, {(TW-1){1'b0}}}, 128'd1, 1'b1,
                {1'b0, {(TW-1){1'b1}}}, 1'b1, 1'b1, 1'b0, 4'b0001};
    vecs[7] = '{"borrow_chain", 128'h1_0000_0000, 128'd1, 1'b1, 128'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 4'b1101};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_in_ready", TW'(in_ready), 1);
    chk("reset_out_valid", TW'(out_valid), 0);
    chk("reset_busy", TW'(busy), 0);
    chk("reset_result", out_result, '0);
    chk("reset_carry", TW'(out_carry), 0);
    chk("reset_overflow", TW'(out_overflow), 0);
    chk("reset_zero", TW'(out_zero), 1);
    check_adder_idle("reset");

    // out_ready while idle must not start anything
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_out_ready_busy", TW'(busy), 0);

    for (int i = 0; i < 8; i++) begin
      issue_and_check(vecs[i]);
      drain(vecs[i].name);
    end

    // Backpressure: result held for 5 cycles, new request ignored meanwhile.
    issue_and_check(vecs[2]);
    held_result = out_result;
    held_carry  = out_carry;
    held_ovf    = out_overflow;
    held_zero   = out_zero;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        in_a = 128'd77; in_b = 128'd11; in_sub = 1'b1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      chk("bp_out_valid", TW'(out_valid), 1);
      chk("bp_in_ready", TW'(in_ready), 0);
      chk("bp_result", out_result, held_result);
      chk("bp_carry", TW'(out_carry), TW'(held_carry));
      chk("bp_overflow", TW'(out_overflow), TW'(held_ovf));
      chk("bp_zero", TW'(out_zero), TW'(held_zero));
    end
    in_valid = 1'b0;
    drain("bp");

    // Reset in the second RUN cycle discards the operation.
    in_a = {TW{1'b1}}; in_b = 128'd1; in_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("midrun_busy", TW'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_rst_in_ready", TW'(in_ready), 1);
    chk("midrun_rst_out_valid", TW'(out_valid), 0);
    chk("midrun_rst_busy", TW'(busy), 0);
    chk("midrun_rst_result", out_result, '0);
    chk("midrun_rst_zero", TW'(out_zero), 1);
    check_adder_idle("midrun_rst");
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("midrun_no_report", TW'(out_valid), 0);
    end
    issue_and_check(vecs[4]);
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wide_addsub_sequencer.md
Name: wide_addsub_sequencer

Overview:
- Multi-precision add/subtract controller. Computes WORDS*WIDTH-bit A±B by sequencing one shared WIDTH-bit carry look-ahead adder, one word per cycle, LSW first, chaining carry through a register.
- Sits between the ALU issue logic (valid/ready request) and the adder instance. Drives the adder's a/b/cin/mode inputs and samples its sum/cout in the same cycle; the adder is purely combinational.

Parameters:
- WIDTH, 32, adder word width in bits.
- WORDS, 4, number of words per operand; total operand width is WORDS*WIDTH. Legal range is ≥2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block accepts a request this cycle.
- in_a  input  WORDS*WIDTH  operand A.
- in_b  input  WORDS*WIDTH  operand B.
- in_sub  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WORDS*WIDTH  sum/difference, modulo 2^(WORDS*WIDTH).
- out_carry  output  1  final adder cout. For subtract, 1 = no borrow.
- out_overflow  output  1  two's-complement signed overflow.
- out_zero  output  1  out_result == 0.
- busy  output  1  high in RUN or DONE.
- adder_a  output  WIDTH  to adder a.
- adder_b  output  WIDTH  to adder b; un-inverted, because the adder applies mode.
- adder_cin  output  1  to adder cin.
- adder_mode  output  1  to adder mode.
- adder_sum  input  WIDTH  from adder sum.
- adder_cout  input  1  from adder cout.

Behaviour:
- FSM states and transitions:
  - IDLE → RUN on in_valid && in_ready.
  - RUN → DONE after the word with idx == WORDS−1 is captured.
  - DONE → IDLE on out_valid && out_ready.
- Output decodes:
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
  - busy = (state != IDLE).
- Accept (IDLE handshake): register in_a, in_b and in_sub. Set idx = 0 and carry_reg = in_sub (the +1 of two's complement). Clear the result register.
- RUN, each cycle:
  - adder_a = a_reg word idx; adder_b = b_reg word idx; adder_cin = carry_reg; adder_mode = sub_reg.
  - On the clock edge: result word idx ← adder_sum; carry_reg ← adder_cout; idx ← idx+1.
  - On the last word, also capture:
    - out_carry ← adder_cout.
    - out_overflow ← (a_msb == (b_msb ^ sub_reg)) && (adder_sum[WIDTH−1] != a_msb), where a_msb and b_msb are the operand top bits.
- adder_a, adder_b, adder_cin and adder_mode are driven to 0 in IDLE and DONE.
- Latency and throughput:
  - Accept at edge 0. RUN occupies cycles 1..WORDS. out_valid rises in cycle WORDS+1.
  - Minimum initiation interval is WORDS+2 cycles. There is no accept in the same cycle as DONE exit.
- DONE:
  - out_result, out_carry, out_overflow and out_zero are stable while out_valid && !out_ready.
  - out_zero is derived from the result register.
- Simultaneous events:
  - in_valid during RUN or DONE is ignored; in_ready = 0 and no state changes.
  - out_ready high in the first DONE cycle completes the transfer that cycle; in_ready = 1 the next cycle.
- Reset (also mid-RUN or mid-DONE), on the next edge:
  - state = IDLE, idx = 0, carry_reg = 0.
  - out_result = 0, out_carry = 0, out_overflow = 0, out_zero = 1 (derived from cleared result).
  - out_valid = 0, busy = 0, in_ready = 1, adder outputs = 0.
  - Any in-flight operation is discarded, not reported.
- out_ready asserted outside DONE has no effect.
- idx width is clog2(WORDS); it never exceeds WORDS−1.

Test Plan:
(WIDTH=32, WORDS=4; values are 128-bit hex.)
1. Add all-ones + 1 → out_result = 0, out_carry = 1, out_zero = 1, out_overflow = 0. adder_cin sequence over RUN cycles 1..4 = 0,1,1,1. out_valid rises in cycle 5.
2. Subtract 0 − 1 → out_result = all-ones, out_carry = 0 (borrow), out_overflow = 0. adder_mode = 1 and first adder_cin = 1 during RUN.
3. Add 0x7FFF…FFFF + 1 → out_result = 0x8000…0000, out_overflow = 1, out_carry = 0.
4. Add 0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF + 1 → out_result = 0x0000_0000_0000_0001_0000_0000_0000_0000. adder_cin over RUN = 0,1,1,0. out_zero = 0.
5. Backpressure: hold out_ready = 0 for 5 cycles after out_valid. Outputs stay stable, in_ready = 0, and a pulsed in_valid with new operands is ignored. After out_ready = 1 for one cycle, in_ready = 1 the next cycle.
6. Assert rst for 1 cycle in the 2nd RUN cycle → next cycle state IDLE, in_ready = 1, out_valid = 0, adder outputs 0. A subsequent 5 + 3 add completes normally with out_result = 8.
